ps2_scancode_decoder: RTL

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_scancode_decoder_if.sv | 28 ++
 rtl/ps2_scancode_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder_if.sv
// Key-event stream from the PS/2 scancode decoder: show-ahead head entry plus a
// consumer accept.
interface ps2_scancode_decoder_if;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_valid;
  logic       ev_ready;

  // Handshake: ev_valid high means ev_code/ev_ext/ev_break describe the head event
  // and hold steady until it is taken; the head is taken on a rising clk edge where
  // ev_valid and ev_ready are both high, and ev_ready with ev_valid low does nothing.
  modport master (
    output ev_code,
    output ev_ext,
    output ev_break,
    output ev_valid,
    input  ev_ready
  );

  modport slave (
    input  ev_code,
    input  ev_ext,
    input  ev_break,
    input  ev_valid,
    output ev_ready
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Turns PS/2 scancode bytes into make/break key events queued in a show-ahead
// FIFO, and tracks shift/ctrl/alt modifier levels.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   decoded_key,
  input  logic                         read_key,
  ps2_scancode_decoder_if.master       ev,
  output logic                         mod_shift,
  output logic                         mod_ctrl,
  output logic                         mod_alt,
  output logic                         overflow,
  output logic [2:0]                   fsm_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PFX_E0   = 3'd1,
    S_PFX_F0   = 3'd2,
    S_PFX_E0F0 = 3'd3,
    S_SKIP_E1  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // read_key crosses into clk here; one strobe per rising edge of the level.
  logic       sync1, sync2, sync3;
  logic       strobe;
  logic [7:0] byte_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      strobe <= 1'b0;
      byte_r <= 8'h00;
    end else begin
      sync1  <= read_key;
      sync2  <= sync1;
      sync3  <= sync2;
      strobe <= sync2 & ~sync3;
      if (sync2 & ~sync3) byte_r <= decoded_key;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode FSM
  state_t     state_q, state_next;
  logic [2:0] skip_cnt, skip_next;
  logic       push;
  logic [7:0] push_code;
  logic       push_ext, push_brk;
  logic       is_filler, is_e0, is_f0, is_e1;

  assign is_e0 = (byte_r == 8'hE0);
  assign is_f0 = (byte_r == 8'hF0);
  assign is_e1 = (byte_r == 8'hE1);
  // Keyboard status/ack bytes that never describe a key.
  assign is_filler = (byte_r == 8'h00) || (byte_r == 8'hAA) || (byte_r == 8'hEE) ||
                     (byte_r == 8'hFA) || (byte_r == 8'hFE) || (byte_r == 8'hFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state_q  <= state_next;
      skip_cnt <= skip_next;
    end
  end

  always_comb begin
    state_next = state_q;
    skip_next  = skip_cnt;
    if (strobe) begin
      case (state_q)
        S_IDLE: begin
          if (is_e0) state_next = S_PFX_E0;
          else if (is_f0) state_next = S_PFX_F0;
          else if (is_e1) begin
            state_next = S_SKIP_E1;
            skip_next  = 3'd7;
          end
        end
        S_PFX_E0: begin
          if (is_f0) state_next = S_PFX_E0F0;
          else if (!is_e0) state_next = S_IDLE;
        end
        S_PFX_F0: begin
          if (!is_f0) state_next = S_IDLE;
        end
        S_PFX_E0F0: begin
          if (!is_e0 && !is_f0) state_next = S_IDLE;
        end
        S_SKIP_E1: begin
          skip_next = (skip_cnt == 3'd0) ? 3'd0 : skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Pause/Break sends eight bytes; the whole burst collapses into one make event.
  always_comb begin
    push      = 1'b0;
    push_code = byte_r;
    push_ext  = 1'b0;
    push_brk  = 1'b0;
    if (strobe) begin
      case (state_q)
        S_IDLE: begin
          push = !is_filler && !is_e0 && !is_f0 && !is_e1;
        end
        S_PFX_E0: begin
          push     = !is_e0 && !is_f0;
          push_ext = 1'b1;
        end
        S_PFX_F0: begin
          push     = !is_f0;
          push_brk = 1'b1;
        end
        S_PFX_E0F0: begin
          push     = !is_e0 && !is_f0;
          push_ext = 1'b1;
          push_brk = 1'b1;
        end
        S_SKIP_E1: begin
          push      = (skip_cnt <= 3'd1);
          push_code = 8'hE1;
          push_ext  = 1'b1;
        end
        default: push = 1'b0;
      endcase
    end
  end

  assign fsm_state = state_q;

  // ---------------------------------------------------------------------------
  // Modifier tracking: bit order lshift, rshift, lctrl, rctrl, lalt, ralt.
  logic [5:0] mods, mods_next;

  always_comb begin
    mods_next = mods;
    if (push) begin
      case ({push_ext, push_code})
        {1'b0, 8'h12}: mods_next[0] = ~push_brk;
        {1'b0, 8'h59}: mods_next[1] = ~push_brk;
        {1'b0, 8'h14}: mods_next[2] = ~push_brk;
        {1'b1, 8'h14}: mods_next[3] = ~push_brk;
        {1'b0, 8'h11}: mods_next[4] = ~push_brk;
        {1'b1, 8'h11}: mods_next[5] = ~push_brk;
        default: mods_next = mods;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mods      <= 6'b0;
      mod_shift <= 1'b0;
      mod_ctrl  <= 1'b0;
      mod_alt   <= 1'b0;
    end else begin
      mods      <= mods_next;
      mod_shift <= mods_next[0] | mods_next[1];
      mod_ctrl  <= mods_next[2] | mods_next[3];
      mod_alt   <= mods_next[4] | mods_next[5];
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead event FIFO; entry layout {code, ext, brk}.
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, head_valid, do_push, do_pop;
  logic [9:0]    head;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign head_valid = (count != '0) && !reset;
  assign do_pop     = head_valid && ev.ev_ready;
  // A pop in the same edge frees the slot, so a full FIFO can still accept.
  assign do_push    = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_code, push_ext, push_brk};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

  assign head        = mem[rd_ptr];
  assign ev.ev_valid = head_valid;
  assign ev.ev_code  = head_valid ? head[9:2] : 8'h00;
  assign ev.ev_ext   = head_valid ? head[1]   : 1'b0;
  assign ev.ev_break = head_valid ? head[0]   : 1'b0;

endmodule
